// File: rtl/morph3x3_bin.sv
// 3x3 binary erode/dilate on a thresholded raster stream; mode is latched at pixel (0,0).
// Fixed 2-cycle latency with no backpressure; the output frame is offset by (+1,+1).
module morph3x3_bin #(
  parameter int U_COL  = 1280,
  parameter int U_ROW  = 720,
  parameter int DATA_W = 8,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_de,
  output logic              out_data,
  output logic              frame_done
);

  localparam int CW = (U_COL > 1) ? $clog2(U_COL) : 1;
  localparam int RW = (U_ROW > 1) ? $clog2(U_ROW) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;

  // Rows r-1 and r-2, one bit per column.
  logic lb1 [U_COL];
  logic lb2 [U_COL];

  // Column history per window row: [0] holds col c-1, [1] holds col c-2.
  logic [1:0] sh0, sh1, sh2;

  logic       s1_de, s1_mode, s1_last;
  logic [8:0] s1_win;

  logic       first_px, last_col, last_row;
  logic       mode_eff, neutral, pix, up1, up2;
  logic       row_ok1, row_ok2, col_ok1, col_ok2;
  logic [8:0] win;

  always_comb begin
    first_px = (col == '0) && (row == '0);
    last_col = (col == CW'(U_COL - 1));
    last_row = (row == RW'(U_ROW - 1));
    mode_eff = first_px ? mode : mode_q;
    neutral  = ~mode_eff;
    pix      = (in_data >= DATA_W'(THRESH));
    up1      = lb1[col];
    up2      = lb2[col];
    row_ok1  = (row != '0);
    row_ok2  = (row > RW'(1));
    col_ok1  = (col != '0);
    col_ok2  = (col > CW'(1));

    // Missing taps above or left of the frame take the neutral value, which also
    // hides whatever the line buffers and shift registers held before.
    win[0] = pix;
    win[1] = col_ok1 ? sh0[0] : neutral;
    win[2] = col_ok2 ? sh0[1] : neutral;
    win[3] = row_ok1 ? up1 : neutral;
    win[4] = (row_ok1 && col_ok1) ? sh1[0] : neutral;
    win[5] = (row_ok1 && col_ok2) ? sh1[1] : neutral;
    win[6] = row_ok2 ? up2 : neutral;
    win[7] = (row_ok2 && col_ok1) ? sh2[0] : neutral;
    win[8] = (row_ok2 && col_ok2) ? sh2[1] : neutral;
  end

  // Reads above happen combinationally, so these writes never disturb the same beat.
  always_ff @(posedge clk) begin
    if (in_de) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
      sh0    <= '0;
      sh1    <= '0;
      sh2    <= '0;
    end else if (in_de) begin
      mode_q <= mode_eff;
      sh0    <= {sh0[0], pix};
      sh1    <= {sh1[0], up1};
      sh2    <= {sh2[0], up2};
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_de      <= 1'b0;
      s1_mode    <= 1'b0;
      s1_last    <= 1'b0;
      s1_win     <= '0;
      out_de     <= 1'b0;
      out_data   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      s1_de      <= in_de;
      s1_mode    <= mode_eff;
      s1_last    <= in_de && last_col && last_row;
      s1_win     <= in_de ? win : '0;
      out_de     <= s1_de;
      out_data   <= s1_de && (s1_mode ? (|s1_win) : (&s1_win));
      frame_done <= s1_de && s1_last;
    end
  end

endmodule

// File: tb/tb_morph3x3_bin.sv
// Self-checking bench for morph3x3_bin on an 8x6 frame against a direct 3x3 window model.
module tb_morph3x3_bin;

  localparam int UC = 8;
  localparam int UR = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       in_de = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_de, out_data, frame_done;

  always #5 clk = ~clk;

  morph3x3_bin #(.U_COL(UC), .U_ROW(UR), .DATA_W(8), .THRESH(128)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_de(in_de), .in_data(in_data),
    .out_de(out_de), .out_data(out_data), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct { bit d; bit fd; } exp_t;
  exp_t q[$];
  int   m_r = 0, m_c = 0;
  bit   m_mode = 1'b0;
  bit   pix [UR][UC];

  // Reference: binarise, then AND/OR the 3x3 neighbourhood ending at (r,c).
  task automatic model_push(input logic [7:0] d, input bit md);
    bit acc, t;
    int rr, cc;
    exp_t e;
    if (m_r == 0 && m_c == 0) m_mode = md;
    pix[m_r][m_c] = (d >= 8'd128);
    acc = !m_mode;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        rr = m_r - dr;
        cc = m_c - dc;
        t = (rr < 0 || cc < 0) ? !m_mode : pix[rr][cc];
        acc = m_mode ? (acc | t) : (acc & t);
      end
    e.d  = acc;
    e.fd = (m_r == UR - 1) && (m_c == UC - 1);
    q.push_back(e);
    m_c++;
    if (m_c == UC) begin
      m_c = 0;
      m_r = (m_r == UR - 1) ? 0 : m_r + 1;
    end
  endtask

  bit   h1 = 1'b0, h2 = 1'b0;
  exp_t got;

  always @(negedge clk) begin
    if (!rst_n) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      check("out_de", out_de, h2);
      if (h2) begin
        check("exp_avail", q.size() > 0, 1);
        if (q.size() > 0) begin
          got = q.pop_front();
          check("out_data", out_data, got.d);
          check("frame_done", frame_done, got.fd);
        end
      end else begin
        check("idle_data", out_data, 0);
        check("idle_fd", frame_done, 0);
      end
      h2 = h1;
      h1 = in_de;
    end
  end

  task automatic beat(input logic [7:0] d, input bit md, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      in_de   = 1'b0;
      in_data = 8'($urandom);
      mode    = 1'($urandom);
    end
    @(posedge clk); #1;
    in_de   = 1'b1;
    in_data = d;
    mode    = md;
    model_push(d, md);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_de = 1'b0;
    #1;
    check("rst_out_de", out_de, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    q.delete();
    m_r = 0;
    m_c = 0;
    m_mode = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // kind 0: constant lo; kind 1: hi at (pr,pc) over lo; kind 2: random pixels.
  task automatic frame(input int kind, input logic [7:0] lo, input logic [7:0] hi,
                       input int pr, input int pc, input bit m0, input bit m1,
                       input int sw, input int maxgap, input int rst_at);
    logic [7:0] d;
    int idx;
    for (int r = 0; r < UR; r++)
      for (int c = 0; c < UC; c++) begin
        idx = r * UC + c;
        if (idx == rst_at) begin
          do_reset();
          return;
        end
        if (kind == 2) d = 8'($urandom);
        else d = (kind == 1 && r == pr && c == pc) ? hi : lo;
        beat(d, (idx >= sw) ? m1 : m0, (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_de = 1'b0;
    end
  endtask

  initial begin
    #12;
    check("reset_out_de", out_de, 0);
    check("reset_out_data", out_data, 0);
    check("reset_frame_done", frame_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    frame(0, 8'd255, 8'd0, 0, 0, 1'b0, 1'b0, 999, 0, -1);   // erode all-ones
    frame(0, 8'd0,   8'd0, 0, 0, 1'b1, 1'b1, 999, 0, -1);   // dilate all-zeros
    idle(4);
    frame(1, 8'd0, 8'd255, 2, 3, 1'b1, 1'b1, 999, 0, -1);   // single pixel dilate
    frame(1, 8'd0, 8'd255, 2, 3, 1'b0, 1'b0, 999, 0, -1);   // single pixel erode
    frame(0, 8'd128, 8'd0, 0, 0, 1'b0, 1'b0, 999, 0, -1);   // threshold inclusive
    frame(0, 8'd127, 8'd0, 0, 0, 1'b1, 1'b1, 999, 0, -1);
    frame(1, 8'd200, 8'd127, 3, 4, 1'b0, 1'b0, 999, 0, -1);
    frame(1, 8'd0, 8'd255, 2, 3, 1'b1, 1'b1, 999, 5, -1);   // gapped input
    frame(1, 8'd0, 8'd255, 2, 3, 1'b0, 1'b1, 3 * UC, 0, -1); // mode raised mid-frame
    frame(1, 8'd0, 8'd255, 2, 3, 1'b1, 1'b1, 999, 0, -1);
    frame(2, 8'd0, 8'd0, 0, 0, 1'b1, 1'b1, 999, 0, -1);
    frame(2, 8'd0, 8'd0, 0, 0, 1'b0, 1'b0, 999, 0, 2 * UC + 5); // reset at (2,5)
    frame(0, 8'd0, 8'd0, 0, 0, 1'b1, 1'b1, 999, 0, -1);     // stale 1s must not leak
    frame(0, 8'd255, 8'd0, 0, 0, 1'b0, 1'b0, 999, 2, -1);
    for (int f = 0; f < 4; f++)
      frame(2, 8'd0, 8'd0, 0, 0, 1'($urandom), 1'($urandom), $urandom_range(UR * UC - 1, 0), 3, -1);
    idle(6);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
